// File: rtl/intc_source.sv
// intc_source - device-side interrupt front end for the control register file.
//
// Purpose:
//   Synchronises asynchronous device IRQ lines and edge-detects them. Each
//   rising edge becomes a one-cycle pulse on `interrupts`, which the control
//   register file ORs into ISR. Lines marked in LEVEL_MASK are re-armed after
//   their interrupt is taken while the line is still high. The module also
//   watches the resulting `interrupt_state` and raises one prioritised request
//   with a vector number. The request is held until exception entry
//   acknowledges it or the pending bit is withdrawn.
//
// Parameters:
//   NUM_IRQ     - number of device lines (1..16); unused pulse bits are 0.
//   SYNC_STAGES - synchroniser depth per line (2..4).
//   LEVEL_MASK  - bit i set makes line i level-type (re-armed after take).
//
// Ports:
//   clk             in   1        system clock
//   rst             in   1        synchronous, active-high reset
//   clk_en          in   1        pipeline clock enable (request FSM only)
//   irq_in          in   NUM_IRQ  asynchronous device lines, active-high
//   interrupts      out  16       one-cycle pulses to ISR
//   interrupt_state in   32       (ISR & IMR) when IMR[31] set, else 0
//   take_ack        in   1        interrupt exception entry reached WB
//   irq_req         out  1        interrupt request to pipeline
//   irq_vec         out  4        vector of the request (lowest index wins)
//   take_count      out  32       takes seen in REQ (INTC_TAKE_COUNT_EN only)
//
// Optional feature macro: INTC_TAKE_COUNT_EN
//   When defined, adds the `take_count` port. The counter increments on every
//   acknowledged take while in REQ and wraps. Under SIMULATION, one line is
//   printed per take.

module intc_source #(
  parameter int          NUM_IRQ     = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] LEVEL_MASK  = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        interrupts,
  input  logic [31:0]        interrupt_state,
  input  logic               take_ack,
  output logic               irq_req,
  output logic [3:0]         irq_vec
`ifdef INTC_TAKE_COUNT_EN
  ,
  output logic [31:0]        take_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] sync_prev;
  logic [15:0]        pulse_next;
  logic [3:0]         pri_vec;
  logic               any_pending;
  logic               vec_active;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain plus one stage of history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      sync_prev <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      sync_prev <= sync_s;
    end
  end

  // A pulse comes from a fresh rising edge. It can also come from a level
  // line whose take was just acknowledged while the line is still asserted.
  // The re-arm term is ORed per bit, so it cannot be lost to another line's
  // edge that pulses in the same cycle. Bits at or above NUM_IRQ stay 0.
  always_comb begin
    pulse_next = 16'h0000;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pulse_next[i] = (sync_s[i] & ~sync_prev[i]) |
                      (LEVEL_MASK[i] & take_ack & (irq_vec == 4'(i)) & sync_s[i]);
    end
  end

  // The pulse path runs every cycle, regardless of the pipeline clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupts <= 16'h0000;
    end else begin
      interrupts <= pulse_next;
    end
  end

  // Lowest set index of the low half wins. The upper half of
  // interrupt_state does not take part in prioritisation.
  always_comb begin
    pri_vec = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (interrupt_state[i]) begin
        pri_vec = 4'(i);
      end
    end
  end

  assign any_pending = |interrupt_state[15:0];
  assign vec_active  = interrupt_state[irq_vec];

  // Request FSM state register; it only advances on enabled pipeline cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  // The vector is latched only when a request is raised. It stays frozen
  // through REQ and WAIT, which lets a level re-arm match the taken line.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_vec <= 4'd0;
    end else if (clk_en && (state == S_IDLE) && any_pending) begin
      irq_vec <= pri_vec;
    end
  end

  // Next state. A higher-priority bit arriving during REQ does not pre-empt.
  // WAIT holds until exception entry drops the taken bit (normally by
  // clearing IMR[31]), so the same interrupt is not requested twice.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (any_pending) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (take_ack) begin
          state_next = S_WAIT;
        end else if (!vec_active) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if ((interrupt_state == 32'd0) || !vec_active) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // The request is asserted exactly while the FSM sits in REQ.
  always_comb begin
    irq_req = (state == S_REQ);
  end

`ifdef INTC_TAKE_COUNT_EN
  // Counts acknowledged takes. An ack counts only on a cycle where the FSM
  // itself consumes it (in REQ with the pipeline enabled).
  always_ff @(posedge clk) begin
    if (rst) begin
      take_count <= 32'd0;
    end else if (clk_en && (state == S_REQ) && take_ack) begin
      take_count <= take_count + 32'd1;
    end
  end

`ifdef SIMULATION
  always @(posedge clk) begin
    if (!rst && clk_en && (state == S_REQ) && take_ack) begin
      $display("intc_source: take vec=%0d count=%0d", irq_vec, take_count + 32'd1);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_intc_source.sv
// tb_intc_source - directed, self-checking bench for intc_source.
//
// Expected pulses are pushed to a scoreboard queue, each with the cycle on
// which it must appear. Every cycle, the bench pops whatever is due and
// compares it against `interrupts`. Expected irq_req/irq_vec (and take_count
// when INTC_TAKE_COUNT_EN is defined) are kept in bench variables. These are
// updated alongside each directed step.

module tb_intc_source;

  localparam int          SYNC_STAGES = 2;
  localparam int          LAT         = SYNC_STAGES + 1;
  localparam logic [15:0] LEVEL_MASK  = 16'h0002;

  typedef struct {
    int          due;
    logic [15:0] val;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [15:0] irq_in;
  logic [15:0] interrupts;
  logic [31:0] interrupt_state;
  logic        take_ack;
  logic        irq_req;
  logic [3:0]  irq_vec;
`ifdef INTC_TAKE_COUNT_EN
  logic [31:0] take_count;
`endif

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        exp_req;
  logic [3:0]  exp_vec;
  logic [31:0] exp_count;
  sb_entry_t   sb[$];

  intc_source #(
    .NUM_IRQ(16),
    .SYNC_STAGES(SYNC_STAGES),
    .LEVEL_MASK(LEVEL_MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .irq_in(irq_in),
    .interrupts(interrupts),
    .interrupt_state(interrupt_state),
    .take_ack(take_ack),
    .irq_req(irq_req),
    .irq_vec(irq_vec)
`ifdef INTC_TAKE_COUNT_EN
    ,
    .take_count(take_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] irq, input logic [31:0] st,
                               input logic en, input logic ack);
    irq_in          = irq;
    interrupt_state = st;
    clk_en          = en;
    take_ack        = ack;
  endtask

  task automatic expectPulse(input int delay, input logic [15:0] val);
    sb.push_back('{due: cyc + delay, val: val});
  endtask

  task automatic checkOutput();
    logic [15:0] exp_int;
    @(posedge clk);
    #1;
    exp_int = 16'h0000;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        exp_int |= sb[i].val;
        sb.delete(i);
      end
    end
    compare("interrupts", 32'(interrupts), 32'(exp_int));
    compare("irq_req", 32'(irq_req), 32'(exp_req));
    compare("irq_vec", 32'(irq_vec), 32'(exp_vec));
`ifdef INTC_TAKE_COUNT_EN
    compare("take_count", take_count, exp_count);
`endif
  endtask

  initial begin
    // Reset sequencing: all lines high during a two-cycle reset.
    rst = 1'b1;
    applyStimulus(16'hFFFF, 32'h0, 1'b0, 1'b0);
    exp_req = 1'b0; exp_vec = 4'd0; exp_count = 32'd0;
    $display("[TB] reset sequencing");
    checkOutput();
    checkOutput();
    rst = 1'b0;
    expectPulse(LAT, 16'hFFFF);
    repeat (5) checkOutput();

    // Edge vs hold: falling lines give nothing; line 3 held gives one pulse.
    $display("[TB] edge vs hold");
    applyStimulus(16'h0000, 32'h0, 1'b0, 1'b0);
    repeat (4) checkOutput();
    applyStimulus(16'h0008, 32'h0, 1'b0, 1'b0);
    expectPulse(LAT, 16'h0008);
    repeat (20) checkOutput();
    applyStimulus(16'h0000, 32'h0, 1'b0, 1'b0);
    repeat (4) checkOutput();

    // Priority, no pre-emption, take, WAIT hold, back to IDLE.
    $display("[TB] priority");
    applyStimulus(16'h0000, 32'h0000_0024, 1'b1, 1'b0);
    exp_req = 1'b1; exp_vec = 4'd2;
    checkOutput();
    applyStimulus(16'h0000, 32'h0000_0025, 1'b1, 1'b0);
    repeat (2) checkOutput();
    applyStimulus(16'h0000, 32'h0000_0025, 1'b1, 1'b1);
    exp_req = 1'b0; exp_count = exp_count + 32'd1;
    checkOutput();
    applyStimulus(16'h0000, 32'h0000_0025, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(16'h0000, 32'h0, 1'b1, 1'b0);
    checkOutput();

    // Withdrawal of a pending request without an ack.
    $display("[TB] withdrawal");
    applyStimulus(16'h0000, 32'h0000_0020, 1'b1, 1'b0);
    exp_req = 1'b1; exp_vec = 4'd5;
    repeat (2) checkOutput();
    applyStimulus(16'h0000, 32'h0, 1'b1, 1'b0);
    exp_req = 1'b0;
    repeat (2) checkOutput();

    // Clock-enable gating: FSM frozen, pulse path still live.
    $display("[TB] clk_en gating");
    applyStimulus(16'h0001, 32'h0000_0001, 1'b0, 1'b0);
    expectPulse(LAT, 16'h0001);
    repeat (5) checkOutput();
    applyStimulus(16'h0001, 32'h0000_0001, 1'b1, 1'b0);
    exp_req = 1'b1; exp_vec = 4'd0;
    checkOutput();
    applyStimulus(16'h0001, 32'h0, 1'b1, 1'b0);
    exp_req = 1'b0;
    checkOutput();

    // Level re-arm on line 1, coinciding with a fresh edge on line 4.
    $display("[TB] level re-arm");
    applyStimulus(16'h0002, 32'h0, 1'b1, 1'b0);
    expectPulse(LAT, 16'h0002);
    repeat (4) checkOutput();
    applyStimulus(16'h0012, 32'h0000_0002, 1'b1, 1'b0);
    expectPulse(LAT, 16'h0010);
    exp_req = 1'b1; exp_vec = 4'd1;
    checkOutput();
    applyStimulus(16'h0012, 32'h0000_0002, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(16'h0012, 32'h0000_0002, 1'b1, 1'b1);
    expectPulse(1, 16'h0002);
    exp_req = 1'b0; exp_count = exp_count + 32'd1;
    checkOutput();
    applyStimulus(16'h0012, 32'h0, 1'b1, 1'b0);
    repeat (4) checkOutput();

    // Reset has priority over a pending request and a simultaneous ack.
    $display("[TB] reset mid-request");
    applyStimulus(16'h0000, 32'h0000_0008, 1'b1, 1'b0);
    exp_req = 1'b1; exp_vec = 4'd3;
    checkOutput();
    rst = 1'b1;
    applyStimulus(16'h0000, 32'h0000_0008, 1'b1, 1'b1);
    exp_req = 1'b0; exp_vec = 4'd0; exp_count = 32'd0;
    checkOutput();
    rst = 1'b0;
    applyStimulus(16'h0000, 32'h0, 1'b1, 1'b0);
    repeat (3) checkOutput();

    compare("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intc_source.md
Name: intc_source

Overview:
- Device-side interrupt front end that feeds the control register file.
- Synchronises asynchronous device IRQ lines and edge-detects them.
- Emits one-cycle pulses on the 16-bit `interrupts` bus that the control register file ORs into ISR.
- Watches the resulting `interrupt_state` and raises a single prioritised request with vector number to the pipeline, held until exception entry acknowledges it.

Parameters:
- NUM_IRQ, 16, number of device lines; legal 1..16; unused `interrupts` bits tie to 0.
- SYNC_STAGES, 2, synchroniser depth per line; legal 2..4.
- LEVEL_MASK, 16'h0000, bit i = 1 makes line i level-type (re-armed after take), 0 = edge-type.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  pipeline clock enable; gates the request FSM only.
- irq_in  in  NUM_IRQ  asynchronous device lines, active-high.
- interrupts  out  16  one-cycle pulses to control register file ISR.
- interrupt_state  in  32  (ISR & IMR) when IMR[31] is set, else 0.
- take_ack  in  1  interrupt exception entry reached WB (interrupt_in_wb).
- irq_req  out  1  interrupt request to pipeline.
- irq_vec  out  4  vector of the request; lowest set index wins.

Behaviour:
- Reset: sync chains, edge history, `interrupts`, `irq_req`, `irq_vec` and state all go to 0; FSM enters IDLE.
  - `rst` has priority over every other input, including mid-request.
- Synchroniser: SYNC_STAGES flops per line. `s_i` is the last stage. Edge is detected when `s_i & ~prev_i`.
- Pulse path (independent of `clk_en`):
  - Rising edge of `s_i` drives `interrupts[i]` = 1 for exactly the next cycle.
  - Latency from `irq_in` rise to pulse is SYNC_STAGES+1 cycles.
  - A line held high produces one pulse only.
  - Simultaneous edges on several lines pulse together in the same cycle.
- Level re-arm: if LEVEL_MASK[i], `take_ack` with `irq_vec == i` and `s_i` still 1 produce a new pulse 1 cycle after the ack.
  - The re-arm pulse is never merged away, even if an edge for another line pulses in the same cycle.
- Request FSM (advances only when `clk_en` = 1; outputs hold otherwise):
  - IDLE: if `interrupt_state[15:0] != 0`, latch `irq_vec` = index of lowest set bit, set `irq_req` = 1, go to REQ.
  - REQ: `irq_vec` is frozen.
    - If `take_ack`, clear `irq_req` and go to WAIT.
    - Else if `interrupt_state[irq_vec]` = 0 (masked, IMR[31] cleared, or software-cleared ISR), clear `irq_req` and go to IDLE.
    - A higher-priority bit arriving in REQ does not pre-empt.
  - WAIT: go to IDLE when `interrupt_state == 0` or `interrupt_state[irq_vec] == 0`. Entry clears IMR[31], so this normally happens 1 cycle after ack.
  - `take_ack` in IDLE or WAIT is ignored except for level re-arm.
- `interrupt_state[31:16]` is ignored for prioritisation.
- Width rule: `irq_vec` is a 4-bit zero-extended index.
- NUM_IRQ < 16: lines above NUM_IRQ-1 never pulse.

Optional Feature:
- Macro `INTC_TAKE_COUNT_EN`.
- Defined:
  - Adds port `take_count` (out, 32): increments by 1 on every `take_ack` seen in REQ, wraps 32'hFFFFFFFF to 0, reset 0.
  - Under SIMULATION, prints one line per take.
- Undefined: no port, no counter logic; behaviour is otherwise identical.

Test Plan:
- Reset sequencing: `rst` = 1 for 2 cycles with `irq_in` = 16'hFFFF → all outputs 0 during reset. After release, `interrupts` = 16'hFFFF for exactly one cycle, SYNC_STAGES+1 cycles after the first cycle `rst` is low; then 16'h0.
- Edge vs hold: `irq_in[3]` rises and is held 20 cycles (LEVEL_MASK = 0) → exactly one pulse, `interrupts` = 16'h0008.
- Priority: `interrupt_state` = 32'h0000_0024, `clk_en` = 1 → next cycle `irq_req` = 1, `irq_vec` = 2. Then set `interrupt_state` = 32'h0000_0025 → `irq_vec` stays 2. Pulse `take_ack` → `irq_req` = 0; drive `interrupt_state` = 0 → FSM back to IDLE.
- Withdrawal: in REQ with `irq_vec` = 5, drive `interrupt_state` = 0 → `irq_req` drops the next cycle, no ack needed.
- `clk_en` gating: `clk_en` = 0 for 5 cycles with `interrupt_state` = 32'h1 → `irq_req` stays 0. The pulse path still emits a pulse for a concurrent `irq_in[0]` edge.
- Level re-arm: LEVEL_MASK = 16'h0002, `irq_in[1]` held high, take with vec 1 → second pulse 16'h0002 one cycle after `take_ack`. With `INTC_TAKE_COUNT_EN`, `take_count` = 1.
